// File: rtl/symm_fir_tshare_if.sv
// Sample/coefficient/result port bundle for the time-shared symmetric FIR.
// sam_clk_en and coeff_we are single-cycle qualifiers with no back-pressure; y_valid pulses once per accepted strobe.
interface symm_fir_tshare_if #(
  parameter int WIDTH  = 18,
  parameter int ADDR_W = 6
);
  logic                     sam_clk_en;
  logic signed [WIDTH-1:0]  x_in;
  logic                     coeff_we;
  logic        [ADDR_W-1:0] coeff_addr;
  logic signed [WIDTH-1:0]  coeff_data;
  logic signed [WIDTH-1:0]  y;
  logic                     y_valid;
  logic                     y_sat;

  modport master (
    output sam_clk_en, x_in, coeff_we, coeff_addr, coeff_data,
    input  y, y_valid, y_sat
  );

  modport slave (
    input  sam_clk_en, x_in, coeff_we, coeff_addr, coeff_data,
    output y, y_valid, y_sat
  );
endinterface

// File: rtl/symm_fir_tshare.sv
// Odd-length linear-phase FIR: pre-adds mirrored taps, then time-shares NMULT
// multipliers over SHARE cycles per sample, accumulates and saturates to 1s17.
module symm_fir_tshare #(
  parameter int WIDTH  = 18,
  parameter int LENGTH = 101,
  parameter int SHARE  = 4,
  parameter int ADDR_W = 6
) (
  input  logic             sys_clk,
  input  logic             reset,
  symm_fir_tshare_if.slave bus
);
  localparam int HALF  = (LENGTH + 1) / 2;
  localparam int NMULT = (HALF + SHARE - 1) / SHARE;
  localparam int CNT_W = (SHARE > 1) ? $clog2(SHARE) : 1;
  localparam int ACC_W = 2 * WIDTH + $clog2(HALF) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SHARE - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  logic signed [WIDTH-1:0]   h      [HALF];
  logic signed [WIDTH-1:0]   x_line [LENGTH];
  logic signed [WIDTH-1:0]   p      [HALF];
  logic        [CNT_W-1:0]   cnt;
  logic                      busy;
  logic                      strobe;
  logic signed [WIDTH-1:0]   op_a   [NMULT];
  logic signed [WIDTH-1:0]   op_b   [NMULT];
  logic signed [2*WIDTH-1:0] prod   [NMULT];
  logic        [CNT_W-1:0]   prod_ph;
  logic                      prod_v;
  logic                      prod_last;
  logic signed [ACC_W-1:0]   prod_sum;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_sh;
  logic                      acc_done;
  logic signed [WIDTH-1:0]   y_q;
  logic                      y_valid_q;
  logic                      y_sat_q;

  assign strobe = bus.sam_clk_en;

  // Coefficients are configuration, deliberately untouched by reset.
  always_ff @(posedge sys_clk) begin
    if (bus.coeff_we && (int'(bus.coeff_addr) < HALF)) begin
      h[bus.coeff_addr] <= bus.coeff_data;
    end
  end

  // Pre-adders read the line before this strobe's shift.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int i = 0; i < LENGTH; i++) x_line[i] <= '0;
      for (int i = 0; i < HALF; i++) p[i] <= '0;
    end else if (strobe) begin
      x_line[0] <= bus.x_in >>> 1;
      for (int i = 1; i < LENGTH; i++) x_line[i] <= x_line[i-1];
      for (int i = 0; i < HALF - 1; i++) p[i] <= x_line[i] + x_line[LENGTH-1-i];
      p[HALF-1] <= x_line[HALF-1];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cnt  <= CNT_MAX;
      busy <= 1'b0;
    end else if (strobe) begin
      cnt  <= '0;
      busy <= 1'b1;
    end else begin
      if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      if (cnt == CNT_MAX) busy <= 1'b0;
    end
  end

  // Multiplier m serves taps m*SHARE .. m*SHARE+SHARE-1, one per phase.
  always_comb begin
    for (int m = 0; m < NMULT; m++) begin
      op_a[m] = '0;
      op_b[m] = '0;
      for (int s = 0; s < SHARE; s++) begin
        if ((m * SHARE + s < HALF) && (cnt == CNT_W'(s))) begin
          op_a[m] = p[m * SHARE + s];
          op_b[m] = h[m * SHARE + s];
        end
      end
    end
  end

  // A strobe landing mid-computation closes the running sample early so it
  // still yields one (meaningless) result.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int m = 0; m < NMULT; m++) prod[m] <= '0;
      prod_v    <= 1'b0;
      prod_ph   <= '0;
      prod_last <= 1'b0;
    end else begin
      prod_v    <= busy;
      prod_ph   <= cnt;
      prod_last <= (cnt == CNT_MAX) || strobe;
      if (busy) begin
        for (int m = 0; m < NMULT; m++) begin
          prod[m] <= (2*WIDTH)'(op_a[m]) * (2*WIDTH)'(op_b[m]);
        end
      end
    end
  end

  always_comb begin
    prod_sum = '0;
    for (int m = 0; m < NMULT; m++) prod_sum = prod_sum + ACC_W'(prod[m]);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      acc      <= '0;
      acc_done <= 1'b0;
    end else begin
      acc_done <= prod_v && prod_last;
      if (prod_v) acc <= (prod_ph == '0) ? prod_sum : acc + prod_sum;
    end
  end

  // Floor scaling back to 1s17: truncation only, no rounding.
  assign acc_sh = acc >>> (WIDTH - 2);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_sat_q   <= 1'b0;
    end else begin
      y_valid_q <= acc_done;
      if (acc_done) begin
        if (acc_sh > Y_MAX) begin
          y_q     <= Y_MAX[WIDTH-1:0];
          y_sat_q <= 1'b1;
        end else if (acc_sh < Y_MIN) begin
          y_q     <= Y_MIN[WIDTH-1:0];
          y_sat_q <= 1'b1;
        end else begin
          y_q <= acc_sh[WIDTH-1:0];
        end
      end
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.y_sat   = y_sat_q;
endmodule
